async_fifo: RTL and testbench

//   Single-clock synchronous FIFO buffering byte-wide data between a producer and
//   a consumer in the same clock domain. Circular buffer with read/write pointers,

---
 rtl/fifo_pkg.sv | 8 +
 rtl/fifo_mem.sv | 24 ++
 rtl/async_fifo.sv | 44 ++++
 tb/tb_async_fifo.sv | 104 ++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO defaults and pointer width helper
package fifo_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH = 16;
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: register array with one sync write port and one registered read port
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    // storage array, never reset
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    // read register: cleared on reset, holds when no read
    always_ff @(posedge clk)
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/async_fifo.sv
// async_fifo: single-clock FIFO with wrap-bit pointers and registered read data
module async_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W = ptr_width(DEPTH);
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic wr_acc, rd_acc;
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign wr_acc = wr_en && !full && !rst_n;
    assign rd_acc = rd_en && !empty && !rst_n;
    // pointer update; reset is active-high despite the port name
    always_ff @(posedge clk)
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
        end
    fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk(clk),
        .rst(rst_n),
        .we(wr_acc),
        .waddr(wr_ptr[ADDR_W-1:0]),
        .wdata(data_in),
        .re(rd_acc),
        .raddr(rd_ptr[ADDR_W-1:0]),
        .rdata(data_out)
    );
endmodule

// File: tb/tb_async_fifo.sv
// tb_async_fifo: table vectors plus queue scoreboard for async_fifo
module tb_async_fifo;
    localparam int D = 16;
    logic clk = 0, rst_n, wr_en, rd_en;
    logic [7:0] data_in, data_out;
    logic empty, full;
    int n_chk = 0, n_fail = 0;
    logic [7:0] q[$];
    logic [7:0] last = 8'h00;

    async_fifo dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en),
        .data_in(data_in), .data_out(data_out), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst, wr, rd;
        logic [7:0] din, dout;
        logic emp, ful;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic rd, input logic [7:0] din);
        logic wa, ra;
        @(negedge clk);
        rst_n = r; wr_en = w; rd_en = rd; data_in = din;
        wa = w && q.size() < D && !r;
        ra = rd && q.size() > 0 && !r;
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            last = 8'h00;
        end else begin
            if (ra) last = q.pop_front();
            if (wa) q.push_back(din);
        end
        chk("sb_data", data_out, last);
        chk("sb_empty", empty, q.size() == 0);
        chk("sb_full", full, q.size() == D);
    endtask

    initial begin
        rst_n = 1; wr_en = 0; rd_en = 0; data_in = 0;
        tbl[0] = '{1, 0, 0, 8'h00, 8'h00, 1, 0};
        tbl[1] = '{1, 0, 0, 8'h00, 8'h00, 1, 0};
        tbl[2] = '{0, 1, 0, 8'hAA, 8'h00, 0, 0};
        tbl[3] = '{0, 1, 0, 8'h55, 8'h00, 0, 0};
        tbl[4] = '{0, 0, 1, 8'h00, 8'hAA, 0, 0};
        tbl[5] = '{0, 0, 1, 8'h00, 8'h55, 1, 0};
        tbl[6] = '{0, 0, 1, 8'h00, 8'h55, 1, 0};
        tbl[7] = '{0, 1, 1, 8'h3C, 8'h55, 0, 0};
        tbl[8] = '{0, 0, 1, 8'h00, 8'h3C, 1, 0};
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].rst, tbl[i].wr, tbl[i].rd, tbl[i].din);
            chk($sformatf("vec%0d_dout", i), data_out, tbl[i].dout);
            chk($sformatf("vec%0d_empty", i), empty, tbl[i].emp);
            chk($sformatf("vec%0d_full", i), full, tbl[i].ful);
        end
        for (int i = 0; i < D; i++) step(0, 1, 0, 8'(i));
        chk("full_after_16", full, 1);
        step(0, 1, 0, 8'hFF);
        chk("full_after_drop", full, 1);
        step(0, 1, 1, 8'hEE);
        chk("full_rw_head", data_out, 8'h00);
        chk("full_rw_not_full", full, 0);
        for (int i = 1; i < D; i++) begin
            step(0, 0, 1, 8'h00);
            chk("drain_order", data_out, 8'(i));
        end
        chk("drain_empty", empty, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'(8'h40 + i));
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 1, 8'(8'h43 + i));
            chk("rw_order", data_out, 8'(8'h40 + i));
            chk("rw_occupancy", q.size(), 3);
        end
        step(0, 0, 0, 8'h00);
        step(0, 1, 0, 8'h90);
        step(0, 1, 0, 8'h91);
        chk("pre_reset_not_empty", empty, 0);
        step(1, 1, 0, 8'hBB);
        chk("mid_reset_empty", empty, 1);
        chk("mid_reset_dout", data_out, 8'h00);
        step(0, 0, 1, 8'h00);
        chk("after_reset_read_empty", data_out, 8'h00);
        step(0, 1, 0, 8'h77);
        step(0, 0, 1, 8'h00);
        chk("after_reset_rw", data_out, 8'h77);
        chk("after_reset_empty", empty, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
